pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameters SHALL be: DW, default 32, payload width (data, PC, instruction fields); CW, default 19, control width (WB/MEM/EX control bits concatenated).
REQ-002 Parameter SKID SHALL default to 1: 1 gives a two-entry stage with registered in_ready; 0 gives a single-entry stage.
REQ-003 Port CLK SHALL be an input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port RST SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-005 in_valid, in_ready (out), in_data[DW], in_ctrl[CW] SHALL form the upstream handshake port; transfer when in_valid && in_ready.
REQ-006 out_valid, out_ready (in), out_data[DW], out_ctrl[CW] SHALL form the downstream port; transfer when out_valid && out_ready.
REQ-007 Input flush, 1 bit, SHALL mean the hazard unit squashes all held entries this cycle.
REQ-008 Input atomic_in and output atomic_out, 1 bit each, SHALL be the LL/SC marker carried alongside the entry.

Function
REQ-009 The stage SHALL hold 0, 1 or 2 entries; states EMPTY, ONE, TWO; TWO is reachable only when SKID=1.
REQ-010 out_valid SHALL be 1 exactly in ONE and TWO, and the outputs SHALL present the oldest entry.
REQ-011 in_ready SHALL be a registered signal equal to (state != TWO) when SKID=1.
REQ-012 When SKID=0, in_ready SHALL be (state==EMPTY) || out_ready (combinational pass-through).
REQ-013 Latency SHALL be one cycle: an entry accepted at edge N is visible on out_* after edge N.
REQ-014 State transitions: push only -> count+1; pop only -> count-1; simultaneous push and pop -> count unchanged, and in ONE the new entry replaces the old one.
REQ-015 In TWO with a pop, the skid entry SHALL move to the head in the same edge, with no bubble.
REQ-016 A push while full SHALL be impossible by the handshake; if asserted anyway, in_data SHALL be ignored.
REQ-017 flush SHALL take priority over push and pop: next state is EMPTY, and out_ctrl and atomic_out are cleared to 0.
REQ-018 During flush, out_data SHALL retain its last value (payload is not cleared); the upstream handshake that cycle is discarded.
REQ-019 With out_ready=0 (stall), all held entries and outputs SHALL stay bit-stable.
REQ-020 When out_valid=0, out_ctrl SHALL be 0 so downstream sees a bubble (no write/no mem op).
REQ-021 Every output SHALL be driven from a register, except in_ready when SKID=0.

Reset
REQ-022 On RST=1 at an edge, state SHALL go to EMPTY.
REQ-023 On reset, out_valid=0, out_ctrl=0, out_data=0 and atomic_out=0.
REQ-024 in_ready SHALL be 0 during reset and 1 in the first cycle after reset.
REQ-025 RST SHALL override flush and handshakes; reset mid-transfer SHALL drop both entries.

Configuration
REQ-026 Macro PIPE_BUBBLE_CNT_EN, when defined, SHALL add output bubble_cnt[31:0].
REQ-027 With the macro, bubble_cnt SHALL increment once per cycle with out_valid=0, and SHALL be cleared by RST (not by flush).
REQ-028 bubble_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-029 Without PIPE_BUBBLE_CNT_EN, the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-030 A shared package (cpu_types_pkg) SHALL hold typedef stage_cnt_t (enum EMPTY/ONE/TWO) and the localparams for the default control width (WB 4 + MEM 5 + EX 10 = 19).
REQ-031 The single entry register (data+ctrl+atomic, with load enable and ctrl clear) SHALL be a sub-module pipe_entry_reg, instantiated twice; the second instance is omitted when SKID=0.

Verification
REQ-032 Reset: RST=1 for 2 cycles -> out_valid=0, out_ctrl=0, in_ready=0; next cycle in_ready=1.
REQ-033 Streaming: push 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> each appears on out_data one cycle later, state stays ONE, no bubbles.
REQ-034 Backpressure: out_ready=0, push 0xA then 0xB -> state TWO, in_ready=0 next cycle.
REQ-035 Drain after backpressure: raise out_ready -> 0xA then 0xB on consecutive cycles, then EMPTY.
REQ-036 Flush collision: state TWO, flush=1 and in_valid=1 with 0xC the same cycle -> EMPTY, out_ctrl=0, atomic_out=0, 0xC never emitted.
REQ-037 Counter (macro defined): 5 idle cycles after reset -> bubble_cnt=5; flush does not clear it; RST does.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: stage occupancy encoding and default control-field widths.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_cnt_t;

    localparam int unsigned WB_CW   = 4;
    localparam int unsigned MEM_CW  = 5;
    localparam int unsigned EX_CW   = 10;
    localparam int unsigned CTRL_CW = WB_CW + MEM_CW + EX_CW;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry (payload, control, LL/SC marker) with load enable.
// Clear zeroes control and marker only; the payload keeps its last value.
module pipe_entry_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = CTRL_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clr,
    input  logic [DW-1:0] d_data,
    input  logic [CW-1:0] d_ctrl,
    input  logic          d_atomic,
    output logic [DW-1:0] q_data,
    output logic [CW-1:0] q_ctrl,
    output logic          q_atomic
);

    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic          atomic_q, atomic_d;

    always_comb begin
        data_d   = data_q;
        ctrl_d   = ctrl_q;
        atomic_d = atomic_q;
        if (clr) begin
            ctrl_d   = '0;
            atomic_d = 1'b0;
        end else if (load) begin
            data_d   = d_data;
            ctrl_d   = d_ctrl;
            atomic_d = d_atomic;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            ctrl_q   <= '0;
            atomic_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            atomic_q <= atomic_d;
        end
    end

    assign q_data   = data_q;
    assign q_ctrl   = ctrl_q;
    assign q_atomic = atomic_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with optional skid entry and hazard flush.
// Optional feature: define PIPE_BUBBLE_CNT_EN to add the bubble_cnt output.
module pipe_skid_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned CW   = CTRL_CW,
    parameter bit          SKID = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [CW-1:0] in_ctrl,
    input  logic          atomic_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] out_ctrl,
    output logic          atomic_out,
    input  logic          flush
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    output logic [31:0]   bubble_cnt
`endif
);

    stage_cnt_t    state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_d;
    logic          push, pop;
    logic          head_load, head_clr, head_from_skid, skid_load;
    logic [DW-1:0] head_src_data, skid_data;
    logic [CW-1:0] head_src_ctrl, skid_ctrl;
    logic          head_src_atomic, skid_atomic;

    assign push = in_valid && in_ready;
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_clr       = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            head_clr = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push && SKID) begin
                        skid_load = 1'b1;
                        state_d   = TWO;
                    end else if (pop) begin
                        head_clr = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                TWO: begin
                    // Skid entry slides into the head on the same edge as the pop.
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        head_src_data   = in_data;
        head_src_ctrl   = in_ctrl;
        head_src_atomic = atomic_in;
        if (head_from_skid) begin
            head_src_data   = skid_data;
            head_src_ctrl   = skid_ctrl;
            head_src_atomic = skid_atomic;
        end
    end

    pipe_entry_reg #(.DW(DW), .CW(CW)) u_head (
        .clk      (CLK),
        .rst      (RST),
        .load     (head_load),
        .clr      (head_clr),
        .d_data   (head_src_data),
        .d_ctrl   (head_src_ctrl),
        .d_atomic (head_src_atomic),
        .q_data   (out_data),
        .q_ctrl   (out_ctrl),
        .q_atomic (atomic_out)
    );

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            always_ff @(posedge CLK) begin
                if (RST) in_ready_q <= 1'b0;
                else     in_ready_q <= in_ready_d;
            end
            assign in_ready = in_ready_q;

            pipe_entry_reg #(.DW(DW), .CW(CW)) u_skid (
                .clk      (CLK),
                .rst      (RST),
                .load     (skid_load),
                .clr      (flush),
                .d_data   (in_data),
                .d_ctrl   (in_ctrl),
                .d_atomic (atomic_in),
                .q_data   (skid_data),
                .q_ctrl   (skid_ctrl),
                .q_atomic (skid_atomic)
            );
        end else begin : g_single
            logic unused_skid_sigs;

            assign in_ready         = (state_q == EMPTY) || out_ready;
            assign skid_data        = '0;
            assign skid_ctrl        = '0;
            assign skid_atomic      = 1'b0;
            assign unused_skid_sigs = skid_load ^ in_ready_d;
        end
    endgenerate

    assign out_valid = out_valid_q;

`ifdef PIPE_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!out_valid_q && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) bubble_cnt_q <= '0;
        else     bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage against a queue-based occupancy model.
module tb_pipe_skid_stage;
    import cpu_types_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = CTRL_CW;
    localparam int unsigned VW = DW + CW + 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          atomic_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          atomic_out;
    logic          flush = 1'b0;
`ifdef PIPE_BUBBLE_CNT_EN
    logic [31:0]   bubble_cnt;
`endif

    pipe_skid_stage #(.DW(DW), .CW(CW), .SKID(1'b1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .atomic_in  (atomic_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .atomic_out (atomic_out),
        .flush      (flush)
`ifdef PIPE_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic          atomic;
    } ent_t;

    // Reference model: FIFO of up to two entries plus the last payload shown.
    ent_t          mq[$];
    logic [DW-1:0] m_shown = '0;
    logic          m_rdy   = 1'b0;
    int unsigned   m_bub   = 0;
    int unsigned   n_vec   = 0;
    int unsigned   n_err   = 0;

    function automatic logic [VW-1:0] expected();
        logic          v;
        logic [CW-1:0] c;
        logic          a;
        v = (mq.size() > 0);
        c = v ? mq[0].ctrl : {CW{1'b0}};
        a = v ? mq[0].atomic : 1'b0;
        return {v, m_rdy, c, a, m_shown};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {out_valid, in_ready, out_ctrl, atomic_out, out_data};
    endfunction

    task automatic tick();
        logic push, pop;
        ent_t e;
        push = in_valid && m_rdy;
        pop  = (mq.size() > 0) && out_ready;
        e    = '{in_data, in_ctrl, atomic_in};
        @(posedge CLK);
        if (RST) begin
            mq.delete();
            m_shown = '0;
            m_rdy   = 1'b0;
            m_bub   = 0;
        end else begin
            if (mq.size() == 0 && m_bub != 32'hFFFF_FFFF) m_bub++;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(e);
            end
            if (mq.size() > 0) m_shown = mq[0].data;
            m_rdy = (mq.size() < 2);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({out_valid, out_ctrl, atomic_out, out_data, in_ready} !== {1'b0, {CW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b c=%h a=%b d=%h r=%b, expected all zero",
                     out_valid, out_ctrl, atomic_out, out_data, in_ready);
        end
        RST = 1'b0;
        tick();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals [3];
        vals = '{32'h11, 32'h22, 32'h33};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_data   = vals[i];
            in_ctrl   = CW'($urandom);
            atomic_in = 1'($urandom);
            tick();
            n_vec++;
            if (out_data !== vals[i] || out_valid !== 1'b1 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream[%0d]: got d=%h v=%b r=%b, expected d=%h v=1 r=1",
                         i, out_data, out_valid, in_ready, vals[i]);
            end
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL stream_model[%0d]: got %h expected %h", i, observed(), expected());
            end
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_ctrl !== {CW{1'b0}} || out_data !== 32'h33) begin
            n_err++;
            $display("FAIL stream_drain: got v=%b c=%h d=%h, expected v=0 c=0 d=33", out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = {CW{1'b1}};
        atomic_in = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
            n_err++;
            $display("FAIL backpressure_full: got r=%b v=%b d=%h, expected r=0 v=1 d=a", in_ready, out_valid, out_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL drain_b: got v=%b d=%h r=%b, expected v=1 d=b r=1", out_valid, out_data, in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_ctrl !== {CW{1'b0}} || atomic_out !== 1'b0) begin
            n_err++;
            $display("FAIL drain_empty: got v=%b c=%h a=%b, expected 0 0 0", out_valid, out_ctrl, atomic_out);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = {CW{1'b1}};
        atomic_in = 1'b1;
        in_data   = 32'hD1;
        tick();
        in_data = 32'hD2;
        tick();
        flush   = 1'b1;
        in_data = 32'hC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || out_ctrl !== {CW{1'b0}} || atomic_out !== 1'b0 || out_data !== 32'hD1) begin
            n_err++;
            $display("FAIL flush_two: got v=%b c=%h a=%b d=%h, expected v=0 c=0 a=0 d=d1",
                     out_valid, out_ctrl, atomic_out, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0 || out_data === 32'hC) begin
                n_err++;
                $display("FAIL flush_no_emit[%0d]: got v=%b d=%h, expected v=0 and never c", i, out_valid, out_data);
            end
        end
        in_valid = 1'b1;
        in_data  = 32'hD3;
        tick();
        flush   = 1'b1;
        in_data = 32'hC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (observed() !== expected() || out_valid !== 1'b0 || out_data !== 32'hD3) begin
            n_err++;
            $display("FAIL flush_one_push: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            RST       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = $urandom;
            in_ctrl   = CW'($urandom);
            atomic_in = 1'($urandom);
            tick();
            n_vec++;
            if (observed() !== expected()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", i, observed(), expected());
            end
`ifdef PIPE_BUBBLE_CNT_EN
            n_vec++;
            if (bubble_cnt !== m_bub) begin
                n_err++;
                $display("FAIL random_bubble[%0d]: got %0d expected %0d", i, bubble_cnt, m_bub);
            end
`endif
        end
        RST   = 1'b0;
        flush = 1'b0;
    endtask

`ifdef PIPE_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        RST       = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (bubble_cnt !== 32'd5) begin
            n_err++;
            $display("FAIL bubble_idle5: got %0d expected 5", bubble_cnt);
        end
        in_valid = 1'b1;
        in_data  = 32'h55;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if (bubble_cnt !== 32'd6 || bubble_cnt !== m_bub) begin
            n_err++;
            $display("FAIL bubble_flush_keep: got %0d expected 6", bubble_cnt);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_vec++;
        if (bubble_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL bubble_reset: got %0d expected 0", bubble_cnt);
        end
    endtask
`endif

    initial begin
        @(negedge CLK);
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_flush();
        test_random();
`ifdef PIPE_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
